// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types and constants for the gcd core initiator
package gcd_pkg;

    localparam int DEFAULT_W       = 8;
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 1023;
    localparam int DONE_CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FETCH = 2'd3
    } gcd_state_t;

    // Width needed for a counter that must be able to hold the value TIMEOUT itself
    function automatic int timeout_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/gcd_req_fifo.sv
// rtl/gcd_req_fifo.sv - synchronous request FIFO holding operand pairs
module gcd_req_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    // A push while full is dropped even if a pop happens in the same cycle
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents need no reset because the pointers gate every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/gcd_driver.sv
// rtl/gcd_driver.sv - initiator that feeds queued operand pairs to one gcd core
module gcd_driver
    import gcd_pkg::*;
#(
    parameter int W          = DEFAULT_W,
    parameter int FIFO_DEPTH = DEFAULT_DEPTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_a,
    input  logic [W-1:0]          in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_res,
    output logic                  out_err,
    output logic [W-1:0]          gcd_a,
    output logic [W-1:0]          gcd_b,
    output logic                  gcd_start,
    input  logic                  gcd_res_rdy,
    input  logic [W-1:0]          gcd_res,
    output logic                  gcd_res_fetch,
    output logic                  busy,
    output logic [DONE_CNT_W-1:0] done_cnt
);

    localparam int CW  = timeout_cnt_width(TIMEOUT);
    localparam int FAW = $clog2(FIFO_DEPTH);

    gcd_state_t            state_q, state_d;
    logic [CW-1:0]         tcnt_q, tcnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [W-1:0]          out_res_q, out_res_d;
    logic                  out_err_q, out_err_d;
    logic [W-1:0]          gcd_a_q, gcd_a_d;
    logic [W-1:0]          gcd_b_q, gcd_b_d;
    logic                  gcd_start_q, gcd_start_d;
    logic                  gcd_res_fetch_q, gcd_res_fetch_d;
    logic                  busy_q, busy_d;
    logic [DONE_CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic                  in_push;
    logic                  fifo_pop;
    logic [2*W-1:0]        fifo_data;
    logic                  fifo_full, fifo_empty;
    logic [FAW:0]          fifo_count, fifo_count_nxt;
    logic [W-1:0]          fifo_a, fifo_b;

    assign in_ready = !fifo_full;
    assign in_push  = in_valid && in_ready;
    assign fifo_a   = fifo_data[2*W-1:W];
    assign fifo_b   = fifo_data[W-1:0];

    gcd_req_fifo #(
        .DW    (2*W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_push),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Job sequencing, timeout, output slot and done counter next-state logic
    always_comb begin
        state_d         = state_q;
        tcnt_d          = tcnt_q;
        out_valid_d     = out_valid_q;
        out_res_d       = out_res_q;
        out_err_d       = out_err_q;
        gcd_a_d         = gcd_a_q;
        gcd_b_d         = gcd_b_q;
        gcd_start_d     = 1'b0;
        gcd_res_fetch_d = 1'b0;
        done_cnt_d      = done_cnt_q;
        fifo_pop        = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            done_cnt_d  = done_cnt_q + DONE_CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Only dispatch when the slot is free, so results stay in push order,
                // and the core has dropped any previous result
                if (!fifo_empty && !out_valid_q && !gcd_res_rdy) begin
                    fifo_pop = 1'b1;
                    if (fifo_a == '0 || fifo_b == '0) begin
                        out_res_d   = fifo_a | fifo_b;
                        out_err_d   = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        gcd_a_d     = fifo_a;
                        gcd_b_d     = fifo_b;
                        gcd_start_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcd_res_rdy) begin
                    out_res_d       = gcd_res;
                    out_err_d       = 1'b0;
                    out_valid_d     = 1'b1;
                    gcd_res_fetch_d = 1'b1;
                    state_d         = ST_FETCH;
                end else if (tcnt_q == CW'(TIMEOUT)) begin
                    out_res_d       = '0;
                    out_err_d       = 1'b1;
                    out_valid_d     = 1'b1;
                    gcd_res_fetch_d = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end
            ST_FETCH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fifo_count_nxt = fifo_count + (FAW+1)'(in_push) - (FAW+1)'(fifo_pop);
        busy_d         = (state_d != ST_IDLE) || (fifo_count_nxt != '0);
    end

    // State and registered outputs; reset also abandons any job in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            tcnt_q          <= '0;
            out_valid_q     <= 1'b0;
            out_res_q       <= '0;
            out_err_q       <= 1'b0;
            gcd_a_q         <= '0;
            gcd_b_q         <= '0;
            gcd_start_q     <= 1'b0;
            gcd_res_fetch_q <= 1'b0;
            busy_q          <= 1'b0;
            done_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            tcnt_q          <= tcnt_d;
            out_valid_q     <= out_valid_d;
            out_res_q       <= out_res_d;
            out_err_q       <= out_err_d;
            gcd_a_q         <= gcd_a_d;
            gcd_b_q         <= gcd_b_d;
            gcd_start_q     <= gcd_start_d;
            gcd_res_fetch_q <= gcd_res_fetch_d;
            busy_q          <= busy_d;
            done_cnt_q      <= done_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_res       = out_res_q;
    assign out_err       = out_err_q;
    assign gcd_a         = gcd_a_q;
    assign gcd_b         = gcd_b_q;
    assign gcd_start     = gcd_start_q;
    assign gcd_res_fetch = gcd_res_fetch_q;
    assign busy          = busy_q;
    assign done_cnt      = done_cnt_q;

endmodule

// File: tb/tb_gcd_driver.sv
// tb/tb_gcd_driver.sv - bench for gcd_driver with a behavioural core stub
module tb_gcd_driver;

    localparam int TO = 1023;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_res;
    logic        out_err;
    logic [7:0]  gcd_a, gcd_b;
    logic        gcd_start;
    logic        gcd_res_rdy;
    logic [7:0]  gcd_res;
    logic        gcd_res_fetch;
    logic        busy;
    logic [15:0] done_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    gcd_driver #(.W(8), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_res       (out_res),
        .out_err       (out_err),
        .gcd_a         (gcd_a),
        .gcd_b         (gcd_b),
        .gcd_start     (gcd_start),
        .gcd_res_rdy   (gcd_res_rdy),
        .gcd_res       (gcd_res),
        .gcd_res_fetch (gcd_res_fetch),
        .busy          (busy),
        .done_cnt      (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
        int x, y, t;
        x = int'(a);
        y = int'(b);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    // Behavioural core: answers gcd after stub_delay cycles, or never
    int         stub_delay = 5;
    bit         stub_never = 1'b0;
    logic       stub_job;
    logic [7:0] stub_a, stub_b;
    int         stub_cnt;
    int         start_cnt, fetch_cnt, start_cyc;
    int         total_fetch = 0;

    assign gcd_res_rdy = stub_job && (stub_cnt == 0) && !stub_never;

    always @(posedge clk) begin
        if (rst) begin
            stub_job  <= 1'b0;
            stub_cnt  <= 0;
            start_cnt <= 0;
            fetch_cnt <= 0;
            gcd_res   <= '0;
        end else begin
            if (gcd_start) begin
                stub_job  <= 1'b1;
                stub_a    <= gcd_a;
                stub_b    <= gcd_b;
                stub_cnt  <= stub_delay;
                gcd_res   <= gcd_ref(gcd_a, gcd_b);
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
            end else if (stub_job && stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
            end
            if (gcd_res_fetch) begin
                stub_job  <= 1'b0;
                fetch_cnt <= fetch_cnt + 1;
            end
        end
    end

    always @(posedge clk) if (gcd_res_fetch) total_fetch <= total_fetch + 1;

    // Reference model: every accepted pair yields one result, in push order
    logic [8:0] exp_q[$];
    logic [7:0] got_res[$];
    logic       got_err[$];
    int         acc_cyc[$];
    int         model_done = 0;
    bit         hold_v = 1'b0;
    logic [7:0] hold_res;
    logic       hold_err;

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            exp_q.delete();
            got_res.delete();
            got_err.delete();
            acc_cyc.delete();
            model_done = 0;
            hold_v = 1'b0;
        end else begin
            chk("done_cnt", int'(done_cnt), model_done % 65536);
            if (stub_job) begin
                chk("gcd_a_stable", int'(gcd_a), int'(stub_a));
                chk("gcd_b_stable", int'(gcd_b), int'(stub_b));
            end
            if (hold_v) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_res", int'(out_res), int'(hold_res));
                chk("hold_err", int'(out_err), int'(hold_err));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got res %0d err %0d with nothing expected", out_res, out_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_res", int'(out_res), int'(e[7:0]));
                    chk("out_err", int'(out_err), int'(e[8]));
                end
                got_res.push_back(out_res);
                got_err.push_back(out_err);
                acc_cyc.push_back(cyc);
                model_done++;
            end
            hold_v   = out_valid && !out_ready;
            hold_res = out_res;
            hold_err = out_err;
            if (in_valid && in_ready) begin
                if (stub_never && in_a != 0 && in_b != 0) exp_q.push_back({1'b1, 8'd0});
                else exp_q.push_back({1'b0, gcd_ref(in_a, in_b)});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_accept: in_ready stayed %0d for pair (%0d,%0d), expected 1", in_ready, a, b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (int'(done_cnt) != n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done", int'(done_cnt), n);
    endtask

    task automatic check_got(input string name, input int idx, input int res, input int err);
        checks++;
        if (idx >= got_res.size()) begin
            errors++;
            $display("FAIL %s: only %0d results, expected index %0d", name, got_res.size(), idx);
        end else begin
            checks--;
            chk({name, "_res"}, int'(got_res[idx]), res);
            chk({name, "_err"}, int'(got_err[idx]), err);
        end
    endtask

    initial begin
        int n;
        int f0, s0, lat;
        logic [7:0] t3_a[6] = '{8'd60, 8'd30, 8'd9, 8'd14, 8'd8, 8'd5};
        logic [7:0] t3_b[6] = '{8'd48, 8'd24, 8'd6, 8'd21, 8'd12, 8'd7};
        int         t3_r[6] = '{12, 6, 3, 7, 4, 1};

        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_res", int'(out_res), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_gcd_start", int'(gcd_start), 0);
        chk("rst_fetch", int'(gcd_res_fetch), 0);
        chk("rst_gcd_a", int'(gcd_a), 0);
        @(posedge clk);
        #1;

        // 1: single job through the core
        stub_delay = 10;
        out_ready = 1'b1;
        push(8'd60, 8'd48);
        wait_done(1, 100);
        chk("t1_starts", start_cnt, 1);
        chk("t1_fetches", fetch_cnt, 1);
        chk("t1_core_a", int'(stub_a), 60);
        chk("t1_core_b", int'(stub_b), 48);
        check_got("t1", 0, 12, 0);

        // 2: zero operands bypass the core
        do_reset();
        out_ready = 1'b1;
        push(8'd0, 8'd35);
        push(8'd0, 8'd0);
        wait_done(2, 100);
        chk("t2_starts", start_cnt, 0);
        check_got("t2a", 0, 35, 0);
        check_got("t2b", 1, 0, 0);

        // 3: back-pressure fills the FIFO, then results drain in order
        do_reset();
        stub_delay = 3;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(t3_a[i], t3_b[i]);
        @(negedge clk);
        chk("t3_full_in_ready", int'(in_ready), 0);
        in_a = t3_a[5];
        in_b = t3_b[5];
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_still_full", int'(in_ready), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t3_sixth_accept", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(6, 300);
        for (int i = 0; i < 6; i++) check_got("t3", i, t3_r[i], 0);

        // 4: core never answers, job times out
        do_reset();
        stub_never = 1'b1;
        out_ready = 1'b1;
        push(8'd60, 8'd48);
        wait_done(1, TO + 60);
        chk("t4_starts", start_cnt, 1);
        chk("t4_fetches", fetch_cnt, 1);
        check_got("t4", 0, 0, 1);
        if (acc_cyc.size() > 0) begin
            lat = acc_cyc[0] - start_cyc;
            checks++;
            if (lat < TO || lat > TO + 3) begin
                errors++;
                $display("FAIL t4_latency: got %0d cycles, expected %0d..%0d", lat, TO, TO + 3);
            end
        end
        stub_never = 1'b0;

        // 5: reset while waiting on the core
        do_reset();
        stub_delay = 20;
        out_ready = 1'b1;
        push(8'd60, 8'd48);
        n = 0;
        while (start_cnt == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_started", start_cnt, 1);
        repeat (3) @(posedge clk);
        #1;
        f0 = total_fetch;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_in_ready", int'(in_ready), 1);
        repeat (30) @(negedge clk);
        chk("t5_no_fetch", total_fetch, f0);
        stub_delay = 4;
        @(posedge clk);
        #1;
        push(8'd30, 8'd24);
        wait_done(1, 100);
        check_got("t5", 0, 6, 0);

        // 6: result held while consumer stalls; nothing else dispatched
        do_reset();
        stub_delay = 5;
        out_ready = 1'b0;
        push(8'd60, 8'd48);
        push(8'd30, 8'd24);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_valid_seen", int'(out_valid), 1);
        s0 = start_cnt;
        repeat (50) @(negedge clk);
        chk("t6_out_res", int'(out_res), 12);
        chk("t6_out_valid", int'(out_valid), 1);
        chk("t6_busy", int'(busy), 1);
        chk("t6_no_start", start_cnt, s0);
        chk("t6_one_start", start_cnt, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(2, 100);
        check_got("t6a", 0, 12, 0);
        check_got("t6b", 1, 6, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
